dia_mes_contador: RTL
=====================

Name: dia_mes_contador

Overview:
- Calendar day/month stage of the BCD date chain.
- Advances the day-of-month and month digits on each end-of-day carry from the hour stage, using correct month lengths and leap-year handling derived from the year digits.
- Its digit outputs feed the year-digit stages.
- The year stages detect the year rollover from these digits; this block also supplies an explicit end-of-year strobe.

Parameters:
- DIA_INI, 8'h01, BCD day loaded on reset (valid 01..28).
- MES_INI, 5'h01, BCD month loaded on reset (valid 01..12; bit4 = tens digit).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- stay  input  1  1 = run mode (finDia advances date); 0 = set mode (addDia/addMes active).
- finDia  input  1  one-cycle end-of-day carry (23:59:59.99 reached); only honoured when stay=1.
- addDia  input  1  set mode: increment day, wrap within current month, no month carry.
- addMes  input  1  set mode: increment month, 12 wraps to 01, no year carry.
- unidadesYear  input  4  BCD year units.
- decenasYear  input  4  BCD year tens.
- centenasYear  input  4  BCD year hundreds.
- millaresYear  input  4  BCD year thousands.
- unidadesDia  output  4  BCD day units, registered.
- decenasDia  output  2  BCD day tens, registered.
- unidadesMes  output  4  BCD month units, registered.
- decenasMes  output  1  BCD month tens, registered.
- finYear  output  1  combinational: stay & finDia & (date = 31-Dec).

Behaviour:
- Reset (rst=1 at clk edge): day <= DIA_INI, month <= MES_INI. Reset overrides all other inputs.
- Month length, decoded combinationally from the current month:
  - 31 days: 01, 03, 05, 07, 08, 10, 12.
  - 30 days: 04, 06, 09, 11.
  - February: 29 if leap, else 28.
- Leap decode, from BCD digits with no binary conversion:
  - Let Y2 = decenas/unidades and C2 = millares/centenas.
  - Y2 divisible by 4 means: tens even and units in {0,4,8}, or tens odd and units in {2,6}.
  - leap = (Y2 != 00 and Y2 divisible by 4) or (Y2 == 00 and C2 divisible by 4, same BCD rule).
- Run mode (stay=1), on a finDia edge:
  - Day below month length: increment day as BCD. Units 9 -> 0 with tens+1.
  - Day equal to month length: day <= 01 and month increments.
  - Month 12 with day at month length: month <= 01 (year rollover is performed by the year stages).
  - Latency: 1 cycle from the finDia edge to the updated outputs.
- Run mode, finDia=0: hold. addDia/addMes are ignored whenever stay=1.
- Set mode (stay=0): finDia is ignored.
  - addDia alone: increment day; at month length wrap to 01. Month unchanged.
  - addMes alone: increment month, 12 -> 01. If the current day exceeds the new month's length, clamp day to that length in the same cycle (e.g. 31-Jan + addMes -> 28-Feb in a non-leap year).
  - addDia and addMes together: addMes takes priority, addDia is dropped that cycle.
  - Inputs are level-sampled. Each cycle high counts as one increment; debouncing and edge detection are upstream.
- Year digits changing while the day is 29-Feb (set mode, to a non-leap year): day clamps to 28 on the next cycle. Outputs must never show an invalid date for more than 1 cycle.
- finYear: high only in the same cycle as a finDia that rolls 31-Dec to 01-Jan. Never high in set mode.
- Outputs are always valid BCD:
  - unidadesDia 0..9, decenasDia 0..3, day never 00.
  - unidadesMes 0..9, decenasMes 0..1, month never 00.

Optional Feature:
BISIESTO_EN
- Defined: full Gregorian leap logic as above, and the February 29-day path is present.
- Undefined: leap forced to 0, February always 28 days, the 29-Feb clamp logic is removed, and the millaresYear/centenasYear inputs are unused (tie-off allowed).

Test Plan:
- rst=1 for 1 cycle with defaults -> day=01, month=01 on the next cycle, regardless of stay/finDia.
- stay=1, date 30-Apr, one finDia pulse -> 01-May after 1 cycle; finYear=0.
- stay=1, date 31-Dec, finDia pulse -> finYear=1 in that cycle, then 01-Jan.
- With BISIESTO_EN: 28-Feb plus finDia, year 2024 -> 29-Feb; year 1900 -> 01-Mar; year 2000 -> 29-Feb. Without the macro, year 2024 -> 01-Mar.
- stay=0, date 31-Jan, year 2023, addMes -> 28-Feb. addDia at 28-Feb -> 01-Feb. finDia pulses ignored throughout.
- stay=1 with addDia=addMes=1 for 5 cycles -> no change. stay=0 with addDia and addMes both high at 09-Nov -> month 12, day stays 09.

Source files
------------

// File: rtl/dia_mes_contador.sv
// ----------------------------------------------------------------------------
// dia_mes_contador
// Day-of-month / month stage of the BCD calendar chain. Advances the date on
// each end-of-day carry, honours month lengths and leap years (decoded straight
// from the BCD year digits), and supports a set mode for manual adjustment.
//
// Optional feature macro: BISIESTO_EN
//   defined   -> Gregorian leap-year logic, 29-Feb path and 29-Feb clamp present
//   undefined -> February is always 28 days; year inputs are unused
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset (loads DIA_INI/MES_INI)
//   stay          in   1 = run mode (finDia advances), 0 = set mode
//   finDia        in   one-cycle end-of-day carry, run mode only
//   addDia        in   set mode: day + 1, wraps within month
//   addMes        in   set mode: month + 1, 12 -> 01, day clamped to new length
//   unidadesYear  in   BCD year units
//   decenasYear   in   BCD year tens
//   centenasYear  in   BCD year hundreds
//   millaresYear  in   BCD year thousands
//   unidadesDia   out  BCD day units (registered)
//   decenasDia    out  BCD day tens (registered)
//   unidadesMes   out  BCD month units (registered)
//   decenasMes    out  BCD month tens (registered)
//   finYear       out  combinational end-of-year strobe (31-Dec + finDia)
// ----------------------------------------------------------------------------
module dia_mes_contador #(
  parameter logic [7:0] DIA_INI = 8'h01,
  parameter logic [4:0] MES_INI = 5'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stay,
  input  logic       finDia,
  input  logic       addDia,
  input  logic       addMes,
  input  logic [3:0] unidadesYear,
  input  logic [3:0] decenasYear,
  input  logic [3:0] centenasYear,
  input  logic [3:0] millaresYear,
  output logic [3:0] unidadesDia,
  output logic [1:0] decenasDia,
  output logic [3:0] unidadesMes,
  output logic       decenasMes,
  output logic       finYear
);

  logic [3:0] r_dia_u;
  logic [1:0] r_dia_d;
  logic [3:0] r_mes_u;
  logic       r_mes_d;

  // Packed BCD views: {tens, units}. Since units stay below 10, packed
  // magnitude compares match the decimal ordering.
  logic [5:0] w_dia;
  logic [4:0] w_mes;
  logic [5:0] w_dia_n;
  logic [4:0] w_mes_n;
  logic [5:0] w_len;
  logic [5:0] w_len_sig;
  logic [4:0] w_mes_sig;
  logic       w_fin_mes;
  logic       w_leap;

  assign w_dia = {r_dia_d, r_dia_u};
  assign w_mes = {r_mes_d, r_mes_u};

  // Two-digit BCD value divisible by 4: even tens need units 0/4/8, odd tens
  // need units 2/6.
  function automatic logic div4_bcd(input logic [3:0] t, input logic [3:0] u);
    return (!t[0] && (u == 4'd0 || u == 4'd4 || u == 4'd8)) ||
           ( t[0] && (u == 4'd2 || u == 4'd6));
  endfunction

  function automatic logic [5:0] mes_len(input logic [4:0] mes, input logic leap);
    logic [5:0] len;
    case (mes)
      5'h04, 5'h06, 5'h09, 5'h11: len = 6'h30;
      5'h02:                      len = leap ? 6'h29 : 6'h28;
      default:                    len = 6'h31;
    endcase
    return len;
  endfunction

  function automatic logic [5:0] dia_inc(input logic [5:0] d);
    if (d[3:0] == 4'd9) return {d[5:4] + 2'd1, 4'd0};
    else                return {d[5:4], d[3:0] + 4'd1};
  endfunction

  function automatic logic [4:0] mes_inc(input logic [4:0] m);
    if (m == 5'h12)           return 5'h01;
    else if (m[3:0] == 4'd9)  return 5'h10;
    else                      return {m[4], m[3:0] + 4'd1};
  endfunction

`ifdef BISIESTO_EN
  logic w_y_cero;
  // Century years (xx00) are leap only when the century digits divide by 4.
  assign w_y_cero = (decenasYear == 4'd0) && (unidadesYear == 4'd0);
  assign w_leap   = w_y_cero ? div4_bcd(millaresYear, centenasYear)
                             : div4_bcd(decenasYear, unidadesYear);
`else
  logic w_unused;
  assign w_unused = ^{millaresYear, centenasYear, decenasYear, unidadesYear};
  assign w_leap   = 1'b0;
`endif

  assign w_len     = mes_len(w_mes, w_leap);
  assign w_mes_sig = mes_inc(w_mes);
  assign w_len_sig = mes_len(w_mes_sig, w_leap);
  // >= so a transiently out-of-range day still wraps to 01.
  assign w_fin_mes = (w_dia >= w_len);

  always_comb begin
    w_dia_n = w_dia;
    w_mes_n = w_mes;
    if (stay && finDia) begin
      if (w_fin_mes) begin
        w_dia_n = 6'h01;
        w_mes_n = w_mes_sig;
      end else begin
        w_dia_n = dia_inc(w_dia);
      end
    end else if (!stay && addMes) begin
      w_mes_n = w_mes_sig;
      if (w_dia > w_len_sig) w_dia_n = w_len_sig;
    end else if (!stay && addDia) begin
      w_dia_n = w_fin_mes ? 6'h01 : dia_inc(w_dia);
`ifdef BISIESTO_EN
    end else if (w_dia > w_len) begin
      // Year changed under a 29-Feb: pull the day back into range.
      w_dia_n = w_len;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dia_u <= DIA_INI[3:0];
      r_dia_d <= DIA_INI[5:4];
      r_mes_u <= MES_INI[3:0];
      r_mes_d <= MES_INI[4];
    end else begin
      r_dia_u <= w_dia_n[3:0];
      r_dia_d <= w_dia_n[5:4];
      r_mes_u <= w_mes_n[3:0];
      r_mes_d <= w_mes_n[4];
    end
  end

  assign unidadesDia = r_dia_u;
  assign decenasDia  = r_dia_d;
  assign unidadesMes = r_mes_u;
  assign decenasMes  = r_mes_d;
  assign finYear     = stay && finDia && (w_mes == 5'h12) && (w_dia == 6'h31);

endmodule
